serial_subtractor: RTL and testbench
====================================

SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, meaning operand/result width in bits; legal range 2..32.
REQ-002 The block SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 The block SHALL have port rst_n  input  1  reset; one clock, reset asynchronous and active-low.
REQ-004 The block SHALL have port start  input  1  request to begin a subtraction; sampled only in IDLE.
REQ-005 The block SHALL have port a  input  WIDTH  minuend; captured on the accepted start edge.
REQ-006 The block SHALL have port b  input  WIDTH  subtrahend; captured on the accepted start edge.
REQ-007 The block SHALL have port busy  output  1  high while an operation is in SHIFT state.
REQ-008 The block SHALL have port done  output  1  one-cycle completion pulse.
REQ-009 The block SHALL have port diff  output  WIDTH  result a - b modulo 2^WIDTH.
REQ-010 The block SHALL have port borrow_out  output  1  final borrow; 1 when a < b (unsigned).

Function
REQ-011 The block SHALL implement a Moore FSM with states IDLE, SHIFT, DONE; all outputs registered.
REQ-012 IDLE SHALL go to SHIFT on a rising edge with start=1, loading a_reg<=a, b_reg<=b, borrow<=0, count<=0; otherwise IDLE SHALL hold.
REQ-013 Each SHIFT edge SHALL process one bit LSB-first: d = a_reg[0] ^ b_reg[0] ^ borrow; borrow <= (~a_reg[0] & b_reg[0]) | (~(a_reg[0] ^ b_reg[0]) & borrow).
REQ-014 Each SHIFT edge SHALL shift a_reg and b_reg right by one, shift the diff register right by one with d inserted at MSB, and increment count.
REQ-015 SHIFT SHALL go to DONE on the edge that processes bit WIDTH-1 (count = WIDTH-1); SHIFT SHALL last exactly WIDTH cycles.
REQ-016 DONE SHALL last exactly one cycle, then go to IDLE unconditionally.
REQ-017 Latency: for start sampled at edge t0, busy SHALL be 1 from t0 to t0+WIDTH; done SHALL be 1 from t0+WIDTH to t0+WIDTH+1.
REQ-018 diff and borrow_out SHALL be final and stable whenever done=1, and SHALL hold until the next accepted start.
REQ-019 diff SHALL show partial shift contents during SHIFT; consumers SHALL sample only when done=1.
REQ-020 start asserted in SHIFT or DONE SHALL be ignored, with no effect on state, operands or result; it is not queued.
REQ-021 a and b changing after the accepted start edge SHALL NOT affect the running operation.
REQ-022 start held high continuously SHALL start a new operation on the first IDLE edge after DONE, giving back-to-back throughput of one result per WIDTH+2 cycles.
REQ-023 busy and done SHALL never both be 1 in the same cycle.
REQ-024 The count register SHALL be clog2(WIDTH)+1 bits wide and SHALL not wrap within one operation.

Reset
REQ-025 rst_n=0 SHALL immediately, without waiting for clk, force state=IDLE, busy=0, done=0, diff=0, borrow_out=0, count=0, and clear a_reg, b_reg and borrow.
REQ-026 Reset asserted mid-SHIFT SHALL abort the operation with no done pulse; after deassertion the block SHALL wait in IDLE for a new start.
REQ-027 The first accepted start SHALL be on the first rising edge after rst_n deasserts at which start=1.

Verification
REQ-028 WIDTH=8, a=0x5A, b=0x3C, start pulse -> done 8 cycles after start edge; diff=0x1E, borrow_out=0.
REQ-029 a=0x00, b=0x01 -> diff=0xFF, borrow_out=1 (full borrow ripple); a=0x3C, b=0x5A -> diff=0xE2, borrow_out=1.
REQ-030 a=0xFF, b=0xFF -> diff=0x00, borrow_out=0; a=0x80, b=0x00 -> diff=0x80, borrow_out=0.
REQ-031 Start 0x10-0x01, then pulse start with a=0x77 at cycles 3 and 8 (SHIFT, DONE) -> single result diff=0x0F; no second done.
REQ-032 rst_n low at cycle 4 of SHIFT -> outputs zero asynchronously, no done; next start 0x09-0x04 -> diff=0x05.
REQ-033 start held high for 3 ops -> done pulses spaced exactly 10 cycles apart; random a/b sweep matches (a-b) mod 256 and (a<b).

Source files
------------

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: computes a - b LSB-first over WIDTH cycles,
// reporting the difference modulo 2^WIDTH and the final borrow.
module serial_subtractor #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out
);

    // Counter needs to reach WIDTH-1 without wrapping.
    localparam int unsigned CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] a_nxt;
    logic [WIDTH-1:0] b_reg;
    logic [WIDTH-1:0] b_nxt;
    logic [WIDTH-1:0] diff_nxt;
    logic             borrow;
    logic             borrow_nxt;
    logic [CW-1:0]    count;
    logic [CW-1:0]    count_nxt;
    logic             busy_nxt;
    logic             done_nxt;
    logic             borrow_out_nxt;
    logic             d_bit;
    logic             borrow_bit;

    // One full-subtractor slice operating on the current LSBs.
    always_comb begin
        d_bit      = a_reg[0] ^ b_reg[0] ^ borrow;
        borrow_bit = (~a_reg[0] & b_reg[0]) | (~(a_reg[0] ^ b_reg[0]) & borrow);
    end

    // Next-state and next-output logic; busy/done are computed for the
    // state being entered so the registered versions track the state.
    always_comb begin
        state_nxt      = state;
        a_nxt          = a_reg;
        b_nxt          = b_reg;
        diff_nxt       = diff;
        borrow_nxt     = borrow;
        count_nxt      = count;
        busy_nxt       = 1'b0;
        done_nxt       = 1'b0;
        borrow_out_nxt = borrow_out;

        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt  = SHIFT;
                    a_nxt      = a;
                    b_nxt      = b;
                    borrow_nxt = 1'b0;
                    count_nxt  = '0;
                    busy_nxt   = 1'b1;
                end
            end
            SHIFT: begin
                a_nxt      = a_reg >> 1;
                b_nxt      = b_reg >> 1;
                diff_nxt   = {d_bit, diff[WIDTH-1:1]};
                borrow_nxt = borrow_bit;
                count_nxt  = count + CW'(1);
                if (count == CW'(WIDTH - 1)) begin
                    state_nxt      = DONE;
                    done_nxt       = 1'b1;
                    borrow_out_nxt = borrow_bit;
                end else begin
                    busy_nxt = 1'b1;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // State, datapath and output registers; reset clears everything at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            a_reg      <= '0;
            b_reg      <= '0;
            diff       <= '0;
            borrow     <= 1'b0;
            count      <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            borrow_out <= 1'b0;
        end else begin
            state      <= state_nxt;
            a_reg      <= a_nxt;
            b_reg      <= b_nxt;
            diff       <= diff_nxt;
            borrow     <= borrow_nxt;
            count      <= count_nxt;
            busy       <= busy_nxt;
            done       <= done_nxt;
            borrow_out <= borrow_out_nxt;
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed and randomized checks of serial_subtractor against an arithmetic model.
module tb_serial_subtractor;

    localparam int unsigned W = 8;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] diff;
    logic         borrow_out;

    int checks = 0;
    int errors = 0;

    int           ndone;
    int           last_done;
    logic [W-1:0] qa [3];
    logic [W-1:0] qb [3];

    serial_subtractor #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .a          (a),
        .b          (b),
        .busy       (busy),
        .done       (done),
        .diff       (diff),
        .borrow_out (borrow_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // busy and done must be mutually exclusive in every cycle out of reset.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            checks++;
            assert (!(busy && done)) else begin
                errors++;
                $error("FAIL busy_done_overlap: observed busy=%0b done=%0b expected not both", busy, done);
            end
        end
    end

    // One operation from an idle block; start pulses injected at loop steps ga/gb
    // (with a forced to 0x77) must be ignored. Operands are scrambled after capture.
    task automatic run_op(input logic [W-1:0] av, input logic [W-1:0] bv,
                          input int ga, input int gb);
        logic [W-1:0] exp_d;
        logic         exp_b;
        exp_d = W'(av - bv);
        exp_b = (av < bv);
        start = 1'b1;
        a     = av;
        b     = bv;
        tick();
        check("accept_busy", busy, 1);
        check("accept_done", done, 0);
        for (int k = 1; k <= int'(W) + 1; k++) begin
            start = (k == ga) || (k == gb);
            a     = start ? 8'h77 : W'($urandom);
            b     = W'($urandom);
            tick();
            if (k < int'(W)) begin
                check("shift_busy", busy, 1);
                check("shift_done", done, 0);
            end else if (k == int'(W)) begin
                check("done_pulse", done, 1);
                check("done_busy", busy, 0);
                check("diff", diff, exp_d);
                check("borrow_out", borrow_out, exp_b);
            end else begin
                check("done_end", done, 0);
                check("idle_busy", busy, 0);
                check("diff_hold", diff, exp_d);
                check("borrow_hold", borrow_out, exp_b);
            end
        end
        start = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        a     = '0;
        b     = '0;
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_diff", diff, 0);
        check("rst_borrow", borrow_out, 0);
        #12;
        rst_n = 1'b1;
        tick();
        check("idle_after_rst", busy, 0);

        // Directed operand cases.
        run_op(8'h5A, 8'h3C, 0, 0);
        run_op(8'h00, 8'h01, 0, 0);
        run_op(8'h3C, 8'h5A, 0, 0);
        run_op(8'hFF, 8'hFF, 0, 0);
        run_op(8'h80, 8'h00, 0, 0);

        // Start pulses during SHIFT and DONE are ignored and not queued.
        run_op(8'h10, 8'h01, 3, int'(W) + 1);
        for (int i = 0; i < 12; i++) begin
            tick();
            check("no_second_done", done, 0);
            check("no_second_busy", busy, 0);
            check("ignored_diff", diff, 8'h0F);
        end

        // Leave borrow_out=1, then abort a new operation mid-shift.
        run_op(8'h3C, 8'h5A, 0, 0);
        start = 1'b1;
        a     = 8'h5A;
        b     = 8'h3C;
        tick();
        start = 1'b0;
        repeat (3) tick();
        #2;
        rst_n = 1'b0;
        #1;
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_diff", diff, 0);
        check("abort_borrow", borrow_out, 0);
        repeat (2) begin
            tick();
            check("in_rst_done", done, 0);
        end
        #2;
        rst_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            tick();
            check("post_abort_done", done, 0);
            check("post_abort_busy", busy, 0);
        end
        run_op(8'h09, 8'h04, 0, 0);

        // start held high: three back-to-back operations, one result per W+2 cycles.
        for (int i = 0; i < 3; i++) begin
            qa[i] = W'($urandom);
            qb[i] = W'($urandom);
        end
        start     = 1'b1;
        a         = qa[0];
        b         = qb[0];
        ndone     = 0;
        last_done = 0;
        tick();
        for (int c = 1; c <= 34; c++) begin
            tick();
            if (done) begin
                if (ndone == 0) begin
                    check("held_first_latency", c, W);
                end else begin
                    check("held_spacing", c - last_done, W + 2);
                end
                if (ndone < 3) begin
                    check("held_diff", diff, W'(qa[ndone] - qb[ndone]));
                    check("held_borrow", borrow_out, (qa[ndone] < qb[ndone]));
                end
                last_done = c;
                ndone++;
                if (ndone < 3) begin
                    a = qa[ndone];
                    b = qb[ndone];
                end else begin
                    start = 1'b0;
                end
            end
        end
        start = 1'b0;
        check("held_count", ndone, 3);
        repeat (2) tick();

        // Random sweep against (a - b) mod 256 and a < b.
        for (int i = 0; i < 20; i++) begin
            run_op(W'($urandom), W'($urandom), 0, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
